// File: rtl/pdp8_io_mux.sv
// PDP-8 I/O aggregation: priority IOT response mux, masked registered interrupt,
// and a round-robin data-break arbiter with a done-timeout.
module pdp8_io_mux #(
  parameter int unsigned NDEV  = 4,
  parameter int unsigned DW    = 12,
  parameter int unsigned MAW   = 15,
  parameter int unsigned TMO_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NDEV-1:0]     dev_selected,
  input  logic [NDEV*DW-1:0]  dev_data_out,
  input  logic [NDEV-1:0]     dev_data_avail,
  input  logic [NDEV-1:0]     dev_skip,
  input  logic [NDEV-1:0]     dev_clear_ac,
  input  logic [NDEV-1:0]     dev_interrupt,
  input  logic [NDEV-1:0]     int_mask,
  input  logic [NDEV-1:0]     dev_ram_read_req,
  input  logic [NDEV-1:0]     dev_ram_write_req,
  input  logic [NDEV*MAW-1:0] dev_ram_ma,
  input  logic [NDEV*DW-1:0]  dev_ram_out,
  output logic [NDEV-1:0]     dev_ram_done,
  output logic [DW-1:0]       io_data_out,
  output logic                io_data_avail,
  output logic                io_skip,
  output logic                io_clear_ac,
  output logic                io_interrupt,
  output logic                io_ram_read_req,
  output logic                io_ram_write_req,
  output logic [MAW-1:0]      io_ram_ma,
  output logic [DW-1:0]       io_ram_out,
  input  logic                io_ram_done,
  output logic                sel_conflict,
  output logic                ram_timeout,
  input  logic                err_clear
);

  localparam int unsigned IW = (NDEV > 1) ? $clog2(NDEV) : 1;
  localparam logic [TMO_W-1:0] TMO_MAX = '1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e            state_q;
  logic [IW-1:0]     grant_q;
  logic [IW-1:0]     rr_ptr_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [TMO_W-1:0]  tmo_d;
  logic              rd_req_q;
  logic              wr_req_q;
  logic [MAW-1:0]    ma_q;
  logic [DW-1:0]     out_q;
  logic [NDEV-1:0]   done_q;
  logic              int_q;
  logic              conflict_q;
  logic              timeout_q;

  logic [NDEV-1:0]   pending;
  logic              pick_valid;
  logic [IW-1:0]     pick_idx;
  int unsigned       cand;
  logic              multi_sel;
  logic              tmo_fire;

  // Walk from highest to lowest index so the lowest selected channel wins.
  always_comb begin
    io_data_out   = '0;
    io_data_avail = 1'b0;
    io_skip       = 1'b0;
    io_clear_ac   = 1'b0;
    for (int unsigned i = NDEV; i > 0; i--) begin
      if (dev_selected[i-1]) begin
        io_data_out   = dev_data_out[(i-1)*DW +: DW];
        io_data_avail = dev_data_avail[i-1];
        io_skip       = dev_skip[i-1];
        io_clear_ac   = dev_clear_ac[i-1];
      end
    end
  end

  assign pending = dev_ram_read_req | dev_ram_write_req;

  // Scan offsets from far to near so the nearest requester after rr_ptr wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned k = NDEV; k > 0; k--) begin
      cand = (32'(rr_ptr_q) + k - 1) % NDEV;
      if (pending[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = IW'(cand);
      end
    end
  end

  assign multi_sel = $countones(dev_selected) > 1;
  assign tmo_d     = tmo_q + 1'b1;
  assign tmo_fire  = (state_q == BUSY) && !io_ram_done && (tmo_d == TMO_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      tmo_q    <= '0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      ma_q     <= '0;
      out_q    <= '0;
      done_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            state_q  <= BUSY;
            grant_q  <= pick_idx;
            wr_req_q <= dev_ram_write_req[pick_idx];
            rd_req_q <= ~dev_ram_write_req[pick_idx];
            ma_q     <= dev_ram_ma[pick_idx*MAW +: MAW];
            out_q    <= dev_ram_out[pick_idx*DW +: DW];
            tmo_q    <= '0;
          end
        end
        BUSY: begin
          if (io_ram_done || tmo_fire) begin
            state_q  <= DONE;
            rd_req_q <= 1'b0;
            wr_req_q <= 1'b0;
            done_q   <= NDEV'(1) << grant_q;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        DONE: begin
          state_q  <= IDLE;
          done_q   <= '0;
          rr_ptr_q <= (grant_q == IW'(NDEV - 1)) ? '0 : grant_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A new error in the same cycle as err_clear keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      int_q      <= 1'b0;
      conflict_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      int_q <= |(dev_interrupt & int_mask);
      if (multi_sel)      conflict_q <= 1'b1;
      else if (err_clear) conflict_q <= 1'b0;
      if (tmo_fire)       timeout_q  <= 1'b1;
      else if (err_clear) timeout_q  <= 1'b0;
    end
  end

  assign dev_ram_done     = done_q;
  assign io_interrupt     = int_q;
  assign io_ram_read_req  = rd_req_q;
  assign io_ram_write_req = wr_req_q;
  assign io_ram_ma        = ma_q;
  assign io_ram_out       = out_q;
  assign sel_conflict     = conflict_q;
  assign ram_timeout      = timeout_q;

endmodule

// File: tb/tb_pdp8_io_mux.sv
// Bench for pdp8_io_mux: directed scenarios plus randomized traffic, all checked
// against a transaction-level reference model of the mux, flags and arbiter.
module tb_pdp8_io_mux;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  dev_selected = '0, dev_data_avail = '0, dev_skip = '0, dev_clear_ac = '0;
  logic [3:0]  dev_interrupt = '0, int_mask = '0;
  logic [3:0]  dev_ram_read_req = '0, dev_ram_write_req = '0;
  logic [47:0] dev_data_out = '0, dev_ram_out = '0;
  logic [59:0] dev_ram_ma = '0;
  logic [3:0]  dev_ram_done;
  logic [11:0] io_data_out, io_ram_out;
  logic        io_data_avail, io_skip, io_clear_ac, io_interrupt;
  logic        io_ram_read_req, io_ram_write_req, sel_conflict, ram_timeout;
  logic [14:0] io_ram_ma;
  logic        io_ram_done = 1'b0;
  logic        err_clear = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  bit          m_open, m_cool, m_int, m_conf, m_tmo, m_rd, m_wr;
  int          m_ptr, m_g, m_age;
  logic [14:0] m_ma;
  logic [11:0] m_out;
  logic [3:0]  m_done;

  pdp8_io_mux #(.NDEV(4), .DW(12), .MAW(15), .TMO_W(4)) dut (
    .clk(clk), .reset(reset),
    .dev_selected(dev_selected), .dev_data_out(dev_data_out),
    .dev_data_avail(dev_data_avail), .dev_skip(dev_skip), .dev_clear_ac(dev_clear_ac),
    .dev_interrupt(dev_interrupt), .int_mask(int_mask),
    .dev_ram_read_req(dev_ram_read_req), .dev_ram_write_req(dev_ram_write_req),
    .dev_ram_ma(dev_ram_ma), .dev_ram_out(dev_ram_out), .dev_ram_done(dev_ram_done),
    .io_data_out(io_data_out), .io_data_avail(io_data_avail), .io_skip(io_skip),
    .io_clear_ac(io_clear_ac), .io_interrupt(io_interrupt),
    .io_ram_read_req(io_ram_read_req), .io_ram_write_req(io_ram_write_req),
    .io_ram_ma(io_ram_ma), .io_ram_out(io_ram_out), .io_ram_done(io_ram_done),
    .sel_conflict(sel_conflict), .ram_timeout(ram_timeout), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_open = 0; m_cool = 0; m_int = 0; m_conf = 0; m_tmo = 0; m_rd = 0; m_wr = 0;
    m_ptr = 0; m_g = 0; m_age = 0; m_ma = '0; m_out = '0; m_done = '0;
  endtask

  // Advance the model by one clock using the inputs present just before the edge.
  task automatic model_edge();
    bit fire;
    int c;
    fire = 0;
    m_int = |(dev_interrupt & int_mask);
    if ($countones(dev_selected) >= 2) m_conf = 1;
    else if (err_clear)                m_conf = 0;
    if (m_open) begin
      if (io_ram_done || m_age == 15) begin
        fire   = !io_ram_done;
        m_open = 0; m_rd = 0; m_wr = 0; m_cool = 1;
        m_done = 4'b0001 << m_g;
      end else begin
        m_age++;
      end
    end else if (m_cool) begin
      m_cool = 0; m_done = '0; m_ptr = (m_g + 1) % 4;
    end else begin
      for (int k = 0; k < 4; k++) begin
        c = (m_ptr + k) % 4;
        if (!m_open && (dev_ram_read_req[c] || dev_ram_write_req[c])) begin
          m_open = 1; m_g = c; m_age = 1;
          m_wr = dev_ram_write_req[c]; m_rd = !dev_ram_write_req[c];
          m_ma = dev_ram_ma[c*15 +: 15]; m_out = dev_ram_out[c*12 +: 12];
        end
      end
    end
    if (fire)           m_tmo = 1;
    else if (err_clear) m_tmo = 0;
  endtask

  task automatic check_iot();
    logic [11:0] ed;
    logic ea, es, ec;
    bit found;
    ed = '0; ea = 0; es = 0; ec = 0; found = 0;
    for (int i = 0; i < 4; i++) begin
      if (!found && dev_selected[i]) begin
        found = 1; ed = dev_data_out[i*12 +: 12];
        ea = dev_data_avail[i]; es = dev_skip[i]; ec = dev_clear_ac[i];
      end
    end
    chk("iot_data", io_data_out, ed);
    chk("iot_avail", io_data_avail, ea);
    chk("iot_skip", io_skip, es);
    chk("iot_clear_ac", io_clear_ac, ec);
  endtask

  task automatic check_regs();
    chk("interrupt", io_interrupt, m_int);
    chk("sel_conflict", sel_conflict, m_conf);
    chk("ram_timeout", ram_timeout, m_tmo);
    chk("ram_read_req", io_ram_read_req, m_rd);
    chk("ram_write_req", io_ram_write_req, m_wr);
    chk("ram_ma", io_ram_ma, m_ma);
    chk("ram_out", io_ram_out, m_out);
    chk("ram_done", dev_ram_done, m_done);
  endtask

  // Called at posedge+1 with fresh inputs; returns at the next posedge+1.
  task automatic cycle();
    #1;
    check_iot();
    model_edge();
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic drain();
    dev_ram_read_req = '0; dev_ram_write_req = '0; io_ram_done = 1'b1;
    repeat (4) cycle();
    io_ram_done = 1'b0;
  endtask

  task automatic rand_inputs(input int done_pct);
    dev_selected      = 4'($urandom & $urandom);
    dev_data_out      = {$urandom, $urandom};
    dev_data_avail    = 4'($urandom);
    dev_skip          = 4'($urandom);
    dev_clear_ac      = 4'($urandom);
    dev_interrupt     = 4'($urandom);
    int_mask          = 4'($urandom);
    dev_ram_read_req  = 4'($urandom & $urandom);
    dev_ram_write_req = 4'($urandom & $urandom);
    dev_ram_ma        = {$urandom, $urandom};
    dev_ram_out       = {$urandom, $urandom};
    io_ram_done       = ($urandom_range(0, 99) < done_pct);
    err_clear         = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    int grants[$];
    int busy_n, n;
    bit saw_done;
    int exp_order[4];
    exp_order = '{0, 1, 3, 0};

    // reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_regs();
    check_iot();
    reset = 1'b1;

    // IOT priority and sticky conflict
    dev_selected = 4'b0110;
    dev_data_out[12 +: 12] = 12'o1234;
    dev_data_out[24 +: 12] = 12'o7777;
    dev_data_avail = 4'b0100; dev_skip = 4'b0010;
    #1 chk("iot_prio_data", io_data_out, 12'o1234);
    cycle();
    chk("conflict_set", sel_conflict, 1'b1);
    dev_selected = '0; err_clear = 1'b1;
    cycle();
    chk("conflict_clear", sel_conflict, 1'b0);
    err_clear = 1'b0;

    // interrupt mask
    dev_interrupt = 4'b1000; int_mask = 4'b0111;
    cycle();
    cycle();
    chk("int_masked", io_interrupt, 1'b0);
    int_mask = 4'b1111;
    cycle();
    chk("int_unmasked", io_interrupt, 1'b1);

    // round robin: channels 0,1,3 read continuously, done on 2nd BUSY cycle
    dev_ram_read_req = 4'b1011;
    busy_n = 0;
    for (int i = 0; i < 60 && grants.size() < 4; i++) begin
      cycle();
      if (dev_ram_done != 0) grants.push_back($clog2(dev_ram_done));
      busy_n = (io_ram_read_req || io_ram_write_req) ? busy_n + 1 : 0;
      io_ram_done = (busy_n == 2);
    end
    chk("rr_grants", grants.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("rr_order", (grants.size() > i) ? grants[i] : -1, exp_order[i]);
    drain();

    // write with simultaneous read on channel 2
    dev_ram_write_req = 4'b0100; dev_ram_read_req = 4'b0100;
    dev_ram_ma[30 +: 15] = 15'o12345; dev_ram_out[24 +: 12] = 12'o4321;
    cycle();
    chk("wr_req", io_ram_write_req, 1'b1);
    chk("wr_rd_low", io_ram_read_req, 1'b0);
    chk("wr_ma", io_ram_ma, 15'o12345);
    chk("wr_data", io_ram_out, 12'o4321);
    dev_ram_ma[30 +: 15] = 15'o00077; dev_ram_out[24 +: 12] = 12'o0011;
    repeat (3) cycle();
    chk("wr_ma_stable", io_ram_ma, 15'o12345);
    chk("wr_data_stable", io_ram_out, 12'o4321);
    io_ram_done = 1'b1;
    cycle();
    chk("wr_done_pulse", dev_ram_done, 4'b0100);
    io_ram_done = 1'b0; dev_ram_write_req = '0;
    cycle();
    chk("wr_done_single", dev_ram_done, 4'b0000);
    cycle();
    chk("rd_after_wr", io_ram_read_req, 1'b1);
    drain();

    // timeout: memory never answers
    dev_ram_read_req = 4'b0010;
    n = 0; saw_done = 0;
    for (int i = 0; i < 40 && !saw_done; i++) begin
      cycle();
      if (io_ram_read_req) n++;
      if (dev_ram_done != 0) saw_done = 1;
    end
    chk("tmo_busy_cycles", n, 15);
    chk("tmo_done_seen", saw_done, 1'b1);
    chk("tmo_flag", ram_timeout, 1'b1);
    dev_ram_read_req = '0;
    err_clear = 1'b1;
    cycle();
    chk("tmo_clear", ram_timeout, 1'b0);
    err_clear = 1'b0;
    cycle();

    // async reset while BUSY
    dev_interrupt = 4'b0001; int_mask = 4'b0001;
    dev_ram_read_req = 4'b1000;
    cycle();
    chk("pre_rst_busy", io_ram_read_req, 1'b1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("rst_req_drop", io_ram_read_req, 1'b0);
    chk("rst_int_drop", io_interrupt, 1'b0);
    dev_ram_read_req = 4'b1010;
    dev_ram_ma[15 +: 15] = 15'o01111; dev_ram_ma[45 +: 15] = 15'o03333;
    repeat (2) begin
      @(posedge clk);
      #1;
      check_regs();
    end
    reset = 1'b1;
    cycle();
    chk("post_rst_grant_ma", io_ram_ma, 15'o01111);
    drain();

    // randomized traffic
    foreach (exp_order[s]) begin
      for (int i = 0; i < 500; i++) begin
        rand_inputs((s == 1) ? 0 : 20 + 20 * s);
        cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pdp8_io_mux.md
# pdp8_io_mux

Parametrised I/O aggregation block between the PDP-8 CPU core and NDEV peripheral controllers. It replaces the hand-wired per-device muxing with a generic IOT response multiplexer, a masked and registered interrupt combiner, and a round-robin data-break (RAM access) arbiter. The arbiter has a done-timeout. The block sits inside the I/O subsystem, between the devices and the CPU's io_* and io_ram_* ports.

## Interface
- NDEV, 4: number of device channels (2..8); channel 0 has highest IOT priority
- DW, 12: data word width
- MAW, 15: RAM address width (field + address)
- TMO_W, 8: width of the data-break timeout counter; timeout after 2^TMO_W-1 cycles

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- dev_selected  in  NDEV  device decodes the current IOT
- dev_data_out  in  NDEV*DW  device IOT data; channel i at bits [i*DW +: DW]
- dev_data_avail, dev_skip, dev_clear_ac  in  NDEV each  per-device IOT responses
- dev_interrupt  in  NDEV  interrupt requests (level)
- int_mask  in  NDEV  1 = channel may interrupt
- dev_ram_read_req, dev_ram_write_req  in  NDEV each  data-break requests (level, held until done)
- dev_ram_ma  in  NDEV*MAW  request addresses
- dev_ram_out  in  NDEV*DW  write data
- dev_ram_done  out  NDEV  one-cycle completion pulse to the granted channel
- io_data_out  out  DW; io_data_avail, io_skip, io_clear_ac  out  1  muxed IOT response to CPU
- io_interrupt  out  1  registered masked interrupt
- io_ram_read_req, io_ram_write_req  out  1  to memory
- io_ram_ma  out  MAW; io_ram_out  out  DW  registered transaction address/data
- io_ram_done  in  1  memory completion
- sel_conflict  out  1  sticky: more than one dev_selected seen
- ram_timeout  out  1  sticky: data-break aborted on timeout
- err_clear  in  1  synchronous clear of both sticky flags

## Operation
- IOT mux: combinational. The lowest-index asserted dev_selected drives io_data_out, io_data_avail, io_skip and io_clear_ac. With none selected, all four outputs are 0.
- sel_conflict sets on any cycle with two or more dev_selected bits. It clears only on err_clear or reset. If set and err_clear land in the same cycle, the set wins.
- io_interrupt is registered: OR over (dev_interrupt & int_mask).
- Arbiter FSM states: IDLE, BUSY, DONE.
  - IDLE: if any request is pending, pick the first requester at or after rr_ptr (round-robin, wrapping NDEV-1 to 0). Latch the grant index, the op, dev_ram_ma and dev_ram_out. Go to BUSY.
  - BUSY: assert the latched io_ram_read_req or io_ram_write_req. On io_ram_done go to DONE. If the timeout counter reaches 2^TMO_W-1 first, set ram_timeout and go to DONE.
  - DONE: pulse dev_ram_done[grant] and deassert the RAM request. Set rr_ptr = grant+1 mod NDEV. Go to IDLE.
- Read and write requested together by the same channel: write is performed. The read stays pending and is arbitrated later.
- A request withdrawn while BUSY is ignored; the transaction completes normally.
- io_ram_ma and io_ram_out are stable from the BUSY entry until DONE exits.
- Reset mid-transaction: the request drops immediately, the FSM returns to IDLE, rr_ptr returns to 0, and no done pulse is issued.

## Timing
- Reset values: all outputs 0; FSM IDLE; rr_ptr 0; timeout counter 0.
- IOT response: 0-cycle latency. io_interrupt: 1-cycle latency.
- Request sampled in IDLE at edge E: RAM request is asserted after edge E.
- io_ram_done high at edge K: after K the RAM request is low and dev_ram_done is high for exactly one cycle. After K+1 the FSM is IDLE.
- Handshake: a device must drop its request at the edge where it samples dev_ram_done. The earliest next grant is sampled at K+2, so there is no double-grant.
- Timeout counter counts BUSY cycles and clears on BUSY entry.
- Minimum transaction period: 3 cycles when io_ram_done is asserted in the first BUSY cycle.

## Test plan
- IOT priority: NDEV=4, dev_selected=4'b0110, dev_data_out[1]=12'o1234, dev_data_out[2]=12'o7777 -> io_data_out=12'o1234 and sel_conflict=1 next cycle. Pulse err_clear with dev_selected=0 -> sel_conflict=0.
- Interrupt mask: dev_interrupt=4'b1000, int_mask=4'b0111 -> io_interrupt stays 0. Set int_mask[3]=1 -> io_interrupt=1 one cycle later.
- Round-robin: channels 0, 1, 3 request continuously, memory returns done after 2 BUSY cycles -> grant order 0, 1, 3, 0. Each dev_ram_done is a single-cycle pulse on the correct bit.
- Write transaction: channel 2 write, ma=15'o12345, data=12'o4321 -> io_ram_write_req=1, io_ram_ma=15'o12345, io_ram_out=12'o4321, held stable until io_ram_done. Simultaneous read+write on channel 2 -> write first, then read in a later transaction.
- Timeout: TMO_W=4, io_ram_done never asserted -> request drops after 15 BUSY cycles, dev_ram_done pulses, ram_timeout=1.
- Async reset asserted while BUSY -> outputs 0 immediately, no dev_ram_done pulse. After release, the first grant goes to the lowest pending channel.
